// File: rtl/wb_commit_stage_if.sv
// Handshake bundle between execute, the writeback commit stage and the register file write port.
// The stage connects through the slave modport; the execute/register-file side uses master.
interface wb_commit_stage_if #(
  parameter int NUM_SRC        = 11,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  // Both sides use strict valid/ready: a beat transfers on a rising edge where valid and ready
  // are both high; once raised, valid and its payload hold until that edge; ready may change freely.
  logic                            in_valid;
  logic                            in_ready;
  logic [NUM_SRC-1:0]              in_sel;
  logic [NUM_SRC*DATA_WIDTH-1:0]   in_data;
  logic [REG_ADDR_WIDTH-1:0]       in_rd;

  logic                            out_valid;
  logic                            out_ready;
  logic                            out_we;
  logic [REG_ADDR_WIDTH-1:0]       out_rd;
  logic [DATA_WIDTH-1:0]           out_data;

  logic                            sel_error;

  modport slave (
    input  in_valid, in_sel, in_data, in_rd, out_ready,
    output in_ready, out_valid, out_we, out_rd, out_data, sel_error
  );

  modport master (
    output in_valid, in_sel, in_data, in_rd, out_ready,
    input  in_ready, out_valid, out_we, out_rd, out_data, sel_error
  );
endinterface

// File: rtl/wb_commit_stage.sv
// Registered writeback commit stage: resolves the write enable and value from a one-hot select, then
// holds them in a 2-entry skid buffer. Optional macro WB_BYPASS_EN adds a forwarding lookup port.
module wb_commit_stage #(
  parameter int                 NUM_SRC        = 11,
  parameter int                 DATA_WIDTH     = 32,
  parameter int                 REG_ADDR_WIDTH = 5,
  parameter logic [NUM_SRC-1:0] WRITE_MASK     = 11'b00001111111
) (
  input  logic                      clk,
  input  logic                      reset_n,
  wb_commit_stage_if.slave          bus,
`ifdef WB_BYPASS_EN
  input  logic [REG_ADDR_WIDTH-1:0] byp_rs,
  output logic                      byp_hit,
  output logic [DATA_WIDTH-1:0]     byp_data,
`endif
  output logic [1:0]                state_dbg
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [NUM_SRC-1:0] SEL_LSB = {{(NUM_SRC-1){1'b0}}, 1'b1};

  state_t                    state;
  logic                      main_we;
  logic [REG_ADDR_WIDTH-1:0] main_rd;
  logic [DATA_WIDTH-1:0]     main_data;
  logic                      skid_we;
  logic [REG_ADDR_WIDTH-1:0] skid_rd;
  logic [DATA_WIDTH-1:0]     skid_data;
  logic                      sel_error_q;

  logic                      sel_onehot;
  logic                      res_we;
  logic [DATA_WIDTH-1:0]     res_data;
  logic                      push;
  logic                      pop;

  // An invalid select commits a harmless no-write entry rather than being dropped, so ordering holds.
  always_comb begin
    sel_onehot = (bus.in_sel != '0) && ((bus.in_sel & (bus.in_sel - SEL_LSB)) == '0);
    res_data   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      res_data = res_data | (bus.in_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{bus.in_sel[i]}});
    end
    if (!sel_onehot) begin
      res_data = '0;
    end
    res_we = sel_onehot && (|(bus.in_sel & WRITE_MASK)) && (bus.in_rd != '0);
  end

  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= EMPTY;
      main_we     <= 1'b0;
      main_rd     <= '0;
      main_data   <= '0;
      skid_we     <= 1'b0;
      skid_rd     <= '0;
      skid_data   <= '0;
      sel_error_q <= 1'b0;
    end else begin
      sel_error_q <= push & ~sel_onehot;
      case (state)
        EMPTY: begin
          if (push) begin
            main_we   <= res_we;
            main_rd   <= bus.in_rd;
            main_data <= res_data;
            state     <= ONE;
          end
        end
        ONE: begin
          if (push && !pop) begin
            skid_we   <= res_we;
            skid_rd   <= bus.in_rd;
            skid_data <= res_data;
            state     <= FULL;
          end else if (push && pop) begin
            main_we   <= res_we;
            main_rd   <= bus.in_rd;
            main_data <= res_data;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_we   <= skid_we;
            main_rd   <= skid_rd;
            main_data <= skid_data;
            state     <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Head fields are forced to zero while empty so a stale main register never leaks out.
  assign bus.out_we    = bus.out_valid & main_we;
  assign bus.out_rd    = bus.out_valid ? main_rd : '0;
  assign bus.out_data  = bus.out_valid ? main_data : '0;
  assign bus.sel_error = sel_error_q;
  assign state_dbg     = state;

`ifdef WB_BYPASS_EN
  logic main_match;
  logic skid_match;

  // The skid entry is younger, so it takes priority when both entries target the same register.
  always_comb begin
    main_match = (state != EMPTY) && main_we && (main_rd == byp_rs) && (byp_rs != '0);
    skid_match = (state == FULL) && skid_we && (skid_rd == byp_rs) && (byp_rs != '0);
    byp_hit    = main_match | skid_match;
    byp_data   = '0;
    if (skid_match) begin
      byp_data = skid_data;
    end else if (main_match) begin
      byp_data = main_data;
    end
  end
`endif

endmodule
